shift_add_multiplier: RTL



---
 rtl/shift_add_multiplier_pkg.sv | 18 +
 rtl/shift_add_multiplier_add.sv | 26 ++
 rtl/shift_add_multiplier.sv | 92 +++++++++
 3 files changed

// File: rtl/shift_add_multiplier_pkg.sv
// Shared constants for the shift-and-add multiplier and its adder stage.
package shift_add_multiplier_pkg;

  // Default operand width, shared with the ripple adder.
  localparam int DEF_WIDTH = 7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Iteration counter width. The counter must hold the value WIDTH.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/shift_add_multiplier_add.sv
// WIDTH-bit ripple-carry add stage built from a chain of full-adder cells.
module shift_add_multiplier_add
  import shift_add_multiplier_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  logic [WIDTH:0] c;

  assign c[0] = cin;

  // One full-adder cell per bit. The carry ripples from the LSB to the MSB.
  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    assign sum[i]   = x[i] ^ y[i] ^ c[i];
    assign c[i+1]   = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
  end

  assign cout = c[WIDTH];

endmodule

// File: rtl/shift_add_multiplier.sv
// Radix-2 shift-and-add unsigned multiplier. It performs one ripple add per cycle.
module shift_add_multiplier
  import shift_add_multiplier_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = cnt_width(WIDTH);

  state_e             state, state_nxt;
  logic [WIDTH-1:0]   m;        // latched multiplicand
  logic [WIDTH-1:0]   h;        // accumulator upper half
  logic [WIDTH-1:0]   l;        // accumulator lower half; it starts as the multiplier
  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   addend;
  logic [WIDTH-1:0]   sum;
  logic               c;
  logic [2*WIDTH-1:0] shifted;
  logic               last;

  assign addend = l[0] ? m : '0;
  assign last   = (cnt == CW'(1));
  // {c,sum,l} >> 1. The carry lands in the accumulator MSB so it is never lost.
  assign shifted = {c, sum, l[WIDTH-1:1]};

  shift_add_multiplier_add #(.WIDTH(WIDTH)) u_add (
    .x    (h),
    .y    (addend),
    .cin  (1'b0),
    .sum  (sum),
    .cout (c)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state: a start request is only seen in IDLE. DONE always lasts one cycle.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last)  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake outputs decoded from the state
  always_comb begin
    busy = (state == RUN);
    done = (state == DONE);
  end

  // Datapath: load the operands, then iterate. The product is written only on the final iteration.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m       <= '0;
      h       <= '0;
      l       <= '0;
      cnt     <= '0;
      product <= '0;
    end else begin
      unique case (state)
        IDLE: if (start) begin
          m   <= a;
          h   <= '0;
          l   <= b;
          cnt <= CW'(WIDTH);
        end
        RUN: begin
          {h, l} <= shifted;
          cnt    <= cnt - CW'(1);
          if (last) product <= shifted;
        end
        default: ;
      endcase
    end
  end

endmodule
